// File: rtl/skid_fifo_buffer.sv
// skid_fifo_buffer
//   Ready/valid elastic buffer with a configurable depth. Each beat carries a
//   TLAST-style sideband bit. The buffer also reports its occupancy and an
//   almost-full flag. dout, dout_last and dout_valid come straight from flops.
//   din_ready is decoded only from the level register and the flush input, so
//   it never has a combinational path from dout_ready.
//
// Ports
//   clk          clock
//   rst          synchronous reset, active-high; takes priority over flush
//   flush        synchronous clear of all buffered beats
//   din          input data
//   din_last     end-of-packet marker, stored with its data
//   din_valid    input beat valid
//   din_ready    buffer can accept a beat this cycle
//   dout         output data (reads 0 when dout_valid is 0)
//   dout_last    end-of-packet marker for dout (reads 0 when dout_valid is 0)
//   dout_valid   output beat valid
//   dout_ready   consumer accepts the beat
//   level        number of beats held, 0..DEPTH
//   almost_full  level >= AFULL_THRESH
//
// Storage arrangement
//   A circular array of DEPTH entries holds every buffered beat, including
//   the one currently at the head. The output register is a registered copy
//   of the head entry. Because DEPTH is a power of two, the pointers wrap
//   naturally. The output register is reloaded only from the entry that
//   becomes the head after a pop. Without a pop, that entry is unchanged,
//   so dout stays stable while the consumer stalls.
module skid_fifo_buffer #(
  parameter int DIN_WIDTH    = 32,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = 3,
  parameter int LEVEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [DIN_WIDTH-1:0] din,
  input  logic                 din_last,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [DIN_WIDTH-1:0] dout,
  output logic                 dout_last,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [LEVEL_W-1:0]   level,
  output logic                 almost_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH);
  localparam logic [LEVEL_W-1:0] LEVEL_AF   = LEVEL_W'(AFULL_THRESH);

  // Each entry is {last, data}.
  logic [DIN_WIDTH:0] mem [DEPTH];

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_ptr_next;
  logic               accept;
  logic               pop;
  logic [LEVEL_W-1:0] level_after_pop;
  logic [LEVEL_W-1:0] level_next;
  logic [DIN_WIDTH:0] head_next;

  // A full buffer refuses input even if it is popping in the same cycle.
  // This keeps din_ready free of any dependence on dout_ready.
  assign din_ready = (level != LEVEL_FULL) & ~flush;
  assign accept    = din_valid & din_ready;
  assign pop       = dout_valid & dout_ready;

  always_comb begin
    level_after_pop = level - LEVEL_W'(pop);
    level_next      = level_after_pop + LEVEL_W'(accept);
    rd_ptr_next     = rd_ptr + PTR_W'(pop);
    head_next       = '0;
    // After the pop, the new head is either a beat already in the array or,
    // if the array was drained, the beat being accepted right now.
    if (level_after_pop != '0) begin
      head_next = mem[rd_ptr_next];
    end else if (accept) begin
      head_next = {din_last, din};
    end
  end

  // The array data is never cleared. A flush or reset only rewinds the
  // pointers and the level.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= {din_last, din};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      level       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      dout_valid  <= 1'b0;
      dout        <= '0;
      dout_last   <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      level       <= level_next;
      wr_ptr      <= wr_ptr + PTR_W'(accept);
      rd_ptr      <= rd_ptr_next;
      dout_valid  <= (level_next != '0);
      {dout_last, dout} <= head_next;
      almost_full <= (level_next >= LEVEL_AF);
    end
  end

endmodule

// File: tb/tb_skid_fifo_buffer.sv
module tb_skid_fifo_buffer;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [W-1:0]  din;
  logic          din_last;
  logic          din_valid;
  logic          din_ready;
  logic [W-1:0]  dout;
  logic          dout_last;
  logic          dout_valid;
  logic          dout_ready;
  logic [LW-1:0] level;
  logic          almost_full;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: an ordered queue of {last, data} beats.
  logic [W:0] q[$];

  always #5 clk = ~clk;

  skid_fifo_buffer #(.DIN_WIDTH(W), .DEPTH(DEPTH), .AFULL_THRESH(AF)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .din(din), .din_last(din_last), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_last(dout_last), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .level(level), .almost_full(almost_full)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    logic [W:0] head;
    head = (q.size() != 0) ? q[0] : '0;
    chk({tag, ".dout_valid"},  64'(dout_valid),  64'(q.size() != 0));
    chk({tag, ".dout"},        64'(dout),        64'(head[W-1:0]));
    chk({tag, ".dout_last"},   64'(dout_last),   64'(head[W]));
    chk({tag, ".level"},       64'(level),       64'(q.size()));
    chk({tag, ".almost_full"}, 64'(almost_full), 64'(q.size() >= AF));
  endtask

  // One clock cycle. Inputs are driven at the falling edge, din_ready is
  // checked before the rising edge, and the outputs are checked 1 time unit
  // after the rising edge.
  task automatic step(input string tag, input bit v, input logic [W-1:0] d, input bit l,
                      input bit r, input bit f, input bit rs);
    bit exp_ready;
    bit do_pop;
    @(negedge clk);
    din_valid = v; din = d; din_last = l; dout_ready = r; flush = f; rst = rs;
    #1;
    exp_ready = (q.size() != DEPTH) && !f;
    chk({tag, ".din_ready"}, 64'(din_ready), 64'(exp_ready));
    do_pop = (q.size() != 0) && r;
    @(posedge clk);
    if (rs || f) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (v && exp_ready) q.push_back({l, d});
    end
    #1;
    chk_outputs(tag);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; din = '0; din_last = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset");

    // 1: streaming with the consumer always ready.
    step("t1_release", 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step("t1_stream", 1, 32'h10 + i, 0, 1, 0, 0);
    step("t1_drain", 0, 0, 0, 1, 0, 0);

    // 2: fill the buffer while the consumer stalls; the fifth beat is held off.
    for (int i = 0; i < 4; i++) step("t2_fill", 1, 32'hA0 + i, 0, 0, 0, 0);
    step("t2_full_hold", 1, 32'hA4, 0, 0, 0, 0);
    step("t2_full_hold", 1, 32'hA4, 0, 0, 0, 0);

    // 3: drain from full while 0xA4 keeps waiting for din_ready.
    step("t3_first_pop", 1, 32'hA4, 0, 1, 0, 0);
    step("t3_accept", 1, 32'hA4, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step("t3_drain", 0, 0, 0, 1, 0, 0);

    // 4: last markers with a randomly stalling consumer.
    step("t4_push", 1, 32'h1, 0, 1'($urandom_range(0, 1)), 0, 0);
    step("t4_push", 1, 32'h2, 1, 1'($urandom_range(0, 1)), 0, 0);
    step("t4_push", 1, 32'h3, 1, 1'($urandom_range(0, 1)), 0, 0);
    for (int i = 0; i < 8; i++) step("t4_drain", 0, 0, 0, 1'($urandom_range(0, 1)), 0, 0);
    step("t4_flushout", 0, 0, 0, 1, 0, 0);
    step("t4_flushout", 0, 0, 0, 1, 0, 0);
    step("t4_flushout", 0, 0, 0, 1, 0, 0);

    // 5: flush at level 3 while a beat is being offered.
    for (int i = 0; i < 3; i++) step("t5_fill", 1, 32'hB0 + i, 0, 0, 0, 0);
    step("t5_flush", 1, 32'h55, 0, 0, 1, 0);
    step("t5_after", 0, 0, 0, 1, 0, 0);
    step("t5_after", 0, 0, 0, 1, 0, 0);

    // 6: reset at level 2 in the middle of a stream.
    step("t6_fill", 1, 32'hC0, 0, 0, 0, 0);
    step("t6_fill", 1, 32'hC1, 1, 0, 0, 0);
    step("t6_rst", 1, 32'hC2, 0, 1, 0, 1);
    step("t6_push", 1, 32'h77, 0, 0, 0, 0);
    step("t6_alone", 0, 0, 0, 0, 0, 0);
    step("t6_drain", 0, 0, 0, 1, 0, 0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           1'($urandom_range(0, 3) != 0),
           W'($urandom),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
